// File: rtl/load_store_unit.sv
// Memory-stage load/store bridge to a word-organised RAM: word-only RAM accesses,
// read-modify-write for sub-word stores, lane extraction with sign/zero extension.

module lsu_merge_lane (
  input  logic       be,
  input  logic [7:0] wrByte,
  input  logic [7:0] rdByte,
  output logic [7:0] merged
);
  assign merged = be ? wrByte : rdByte;
endmodule

module load_store_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wr_data,
  input  logic [DWIDTH-1:0] mem_rd_data,
  output logic              mem_rdEn,
  output logic              mem_wrEn,
  output logic              mem_isByte,
  output logic              mem_isHalf,
  output logic              mem_isWord
);
  localparam int NUM_LANES = DWIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t state, nextState;

  logic                 rWe, rUns;
  logic [1:0]           rSize, rOff;
  logic [DWIDTH-1:0]    rWdata;
  logic                 accept, reqErr, isStoreWord;
  logic [NUM_LANES-1:0] byteEn;
  logic [DWIDTH-1:0]    wShift, mergedWord, loadData;
  logic [7:0]           rdByte;
  logic [15:0]          rdHalf;

  assign mem_isByte = 1'b0;
  assign mem_isHalf = 1'b0;
  assign mem_isWord = 1'b1;

  assign accept      = req_valid && req_ready;
  assign reqErr      = (req_size == 2'b11) ||
                       (req_size == 2'b01 && req_addr[0]) ||
                       (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign isStoreWord = req_we && (req_size == 2'b10);

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nextState;

  // next state
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = reqErr ? RESP : (isStoreWord ? WR : RD);
      RD:   nextState = WAIT;
      WAIT: nextState = rWe ? WR : RESP;
      WR:   nextState = RESP;
      RESP: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rdEn   = 1'b0;
    mem_wrEn   = 1'b0;
    case (state)
      IDLE: req_ready  = 1'b1;
      RD:   mem_rdEn   = 1'b1;
      WR:   mem_wrEn   = 1'b1;
      RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Halves are aligned here, so a byte-granular shift places both sizes correctly.
  assign byteEn = (rSize == 2'b00) ? (NUM_LANES'(1) << rOff) : (NUM_LANES'(3) << rOff);
  assign wShift = rWdata << {rOff, 3'b000};

  for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
    lsu_merge_lane uLane (
      .be     (byteEn[k]),
      .wrByte (wShift[8*k +: 8]),
      .rdByte (mem_rd_data[8*k +: 8]),
      .merged (mergedWord[8*k +: 8])
    );
  end

  assign rdByte = mem_rd_data[{rOff, 3'b000} +: 8];
  assign rdHalf = mem_rd_data[{rOff[1], 4'b0000} +: 16];

  always_comb begin
    case (rSize)
      2'b00:   loadData = {{(DWIDTH-8){~rUns & rdByte[7]}}, rdByte};
      2'b01:   loadData = {{(DWIDTH-16){~rUns & rdHalf[15]}}, rdHalf};
      default: loadData = mem_rd_data;
    endcase
  end

  // datapath; errors leave mem_addr/mem_wr_data untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rWe         <= 1'b0;
      rUns        <= 1'b0;
      rSize       <= 2'b00;
      rOff        <= 2'b00;
      rWdata      <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else if (accept) begin
      rWe        <= req_we;
      rUns       <= req_unsigned;
      rSize      <= req_size;
      rOff       <= req_addr[1:0];
      rWdata     <= req_wdata;
      resp_err   <= reqErr;
      resp_rdata <= '0;
      if (!reqErr) begin
        mem_addr <= {req_addr[AWIDTH-1:2], 2'b00};
        if (isStoreWord) mem_wr_data <= req_wdata;
      end
    end else if (state == WAIT) begin
      if (rWe) mem_wr_data <= mergedWord;
      else     resp_rdata  <= loadData;
    end
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bridges the core's memory-stage requests to the word-organised data RAM. It accepts one load or store per handshake and always issues full-word accesses to the RAM. Sub-word stores are performed as read-modify-write so neighbouring bytes are preserved. Loads return sign- or zero-extended results, and misaligned accesses are rejected without touching memory.

## Interface
- DWIDTH, 32, data width of the request path and the RAM path
- AWIDTH, 32, byte-address width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  LSU can accept; a transfer occurs when req_valid and req_ready are both high at a rising edge
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  AWIDTH  byte address
- req_wdata  in  DWIDTH  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  DWIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access or illegal size; qualified by resp_valid
- mem_addr  out  AWIDTH  word-aligned address to the RAM (bits [1:0] = 0)
- mem_wr_data  out  DWIDTH  full-word write data
- mem_rd_data  in  DWIDTH  RAM read data, valid the cycle after mem_rdEn
- mem_rdEn, mem_wrEn  out  1  RAM strobes; each pulses for one cycle only
- mem_isByte, mem_isHalf, mem_isWord  out  1  tied to 0, 0, 1 (the LSU always issues word accesses)

## Operation
- States: IDLE, RD, WAIT, WR, RESP.
- All request fields are latched on acceptance.
- Misalignment:
  - half with addr[0] = 1, word with addr[1:0] ≠ 0, or size 11 → error.
  - Bytes are never misaligned.
- IDLE: req_ready = 1.
  - On accept with error → RESP with resp_err = 1.
  - Accept of an aligned store word → WR.
  - Any other accept → RD.
- RD: mem_rdEn = 1, mem_addr = {addr[AWIDTH-1:2], 2'b00}. Next state is WAIT.
- WAIT: mem_rd_data is valid in this cycle.
  - Load: extract the lane and extend, register into resp_rdata, then → RESP.
  - Sub-word store: merge the latched wdata into the read word, register it as the merged word, then → WR.
- Lanes are little-endian:
  - Byte lane k = addr[1:0], bits [8k+7:8k].
  - Half lane = addr[1], bits [16·addr[1]+15 : 16·addr[1]].
- Extension: sign-extend from the lane MSB unless req_unsigned, in which case upper bits are 0. For word loads req_unsigned is ignored.
- WR: mem_wrEn = 1, mem_wr_data = merged word (or raw wdata for a word store). Next state is RESP.
- RESP: resp_valid = 1, req_ready = 0. Next state is IDLE.
- Outside RD and WR, mem_rdEn and mem_wrEn are 0. mem_addr and mem_wr_data hold their last values.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_rdEn 0, mem_wrEn 0, mem_addr 0, mem_wr_data 0.
- Acceptance edge = cycle 0. resp_valid is high in:
  - cycle 1 for an error;
  - cycle 2 for a store word;
  - cycle 3 for any load;
  - cycle 4 for a store byte/half.
- Back-to-back requests: the next request is accepted at the earliest in the IDLE cycle after RESP. req_valid held high during busy states is ignored.
- mem_* strobes and resp_* outputs are Moore outputs of state and registers; there are no combinational paths from req_* to outputs.
- Reset mid-operation:
  - All state is abandoned immediately and outputs take their reset values.
  - If reset asserts before WR, no write is issued and memory is unchanged.
  - No response is produced for the aborted request.
- Errors never assert mem_rdEn or mem_wrEn.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load word 0x10 → mem_wrEn pulse in cycle 1 with mem_addr 0x10. Store resp_valid in cycle 2; the load returns resp_rdata 0xDEADBEEF in cycle 3.
- With 0xDEADBEEF at 0x10, store byte 0x5A to 0x11 → RAM word becomes 0xDEAD5AEF.
  - lb 0x11 → 0x0000005A.
  - lb 0x13 → 0xFFFFFFDE.
  - lbu 0x13 → 0x000000DE.
- With 0xDEADBEEF at 0x10, store half 0x1234 to 0x12 → lw 0x10 returns 0x1234BEEF.
  - lh 0x10 → 0xFFFFBEEF.
  - lhu 0x10 → 0x0000BEEF.
- lw 0x12, lh 0x11, and a size-11 request → each gives resp_valid with resp_err 1 in cycle 1 and resp_rdata 0. No mem strobe occurs and the word at 0x10 is unchanged.
- Store byte 0xFF to 0x10, with rst_n pulsed low during WAIT → no mem_wrEn, all outputs at reset values, and a later lw 0x10 still returns the prior word.
- req_valid held high for three loads → req_ready low from cycle 1 to cycle 3. Each request is accepted in the IDLE cycle after the previous RESP, giving a 4-cycle spacing between responses.
